// File: rtl/prf_wb_arbiter_if.sv
// Writeback request/grant bundle between execution units and the PRF write-port arbiter.
// The requester side uses the master modport; the arbiter uses slave.
interface prf_wb_arbiter_if #(
    parameter int unsigned N_REQ    = 6,
    parameter int unsigned W_PORTS  = 4,
    parameter int unsigned PRN_BITS = 6
);
    logic [N_REQ-1:0]                   req_valid;
    logic [N_REQ-1:0][PRN_BITS-1:0]     req_prn;
    logic [N_REQ-1:0][63:0]             req_data;
    logic [N_REQ-1:0]                   req_ready;
    logic [W_PORTS-1:0]                 wb_wen;
    logic [W_PORTS-1:0][PRN_BITS-1:0]   wb_wprn;
    logic [W_PORTS-1:0][63:0]           wb_wdata;

    modport master (
        output req_valid, req_prn, req_data,
        input  req_ready, wb_wen, wb_wprn, wb_wdata
    );

    modport slave (
        input  req_valid, req_prn, req_data,
        output req_ready, wb_wen, wb_wprn, wb_wdata
    );
endinterface

// File: rtl/prf_wb_arbiter.sv
// Round-robin arbiter granting up to W_PORTS writebacks per cycle onto registered PRF write
// ports; the registered stage doubles as the scheduler wakeup broadcast.
module prf_wb_arbiter #(
    parameter int unsigned N_REQ    = 6,
    parameter int unsigned W_PORTS  = 4,
    parameter int unsigned PRN_BITS = 6
) (
    input logic clk,
    input logic rst,
    prf_wb_arbiter_if.slave bus
);
    localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PtrW-1:0]                  rr_ptr;
    logic [PtrW-1:0]                  last_idx;
    logic [N_REQ-1:0]                 grant;
    logic [W_PORTS-1:0]               port_valid;
    logic [W_PORTS-1:0][PtrW-1:0]     port_sel;
    int unsigned                      idx;
    int unsigned                      cnt;
    int unsigned                      ptr_inc;
    logic                             dup_prn;

    logic [W_PORTS-1:0]               wen_q;
    logic [W_PORTS-1:0][PRN_BITS-1:0] wprn_q;
    logic [W_PORTS-1:0][63:0]         wdata_q;

    // Scan from rr_ptr with wrap; the k-th valid requester found takes port k.
    always_comb begin
        grant      = '0;
        port_valid = '0;
        port_sel   = '0;
        last_idx   = '0;
        cnt        = 0;
        idx        = 0;
        for (int unsigned j = 0; j < N_REQ; j++) begin
            idx = 32'(rr_ptr) + j;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!rst && bus.req_valid[idx] && cnt < W_PORTS) begin
                grant[idx]      = 1'b1;
                port_valid[cnt] = 1'b1;
                port_sel[cnt]   = PtrW'(idx);
                last_idx        = PtrW'(idx);
                cnt             = cnt + 1;
            end
        end
        ptr_inc = 32'(last_idx) + 1;
    end

    assign bus.req_ready = grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            wen_q   <= '0;
            wprn_q  <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= port_valid;
            for (int unsigned k = 0; k < W_PORTS; k++) begin
                if (port_valid[k]) begin
                    wprn_q[k]  <= bus.req_prn[port_sel[k]];
                    wdata_q[k] <= bus.req_data[port_sel[k]];
                end
            end
            if (|grant) rr_ptr <= (ptr_inc >= N_REQ) ? '0 : PtrW'(ptr_inc);
        end
    end

    assign bus.wb_wen   = wen_q;
    assign bus.wb_wprn  = wprn_q;
    assign bus.wb_wdata = wdata_q;

    // Two valid requesters targeting the same PRN is an upstream rename bug.
    always_comb begin
        dup_prn = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = i + 1; j < N_REQ; j++) begin
                if (bus.req_valid[i] && bus.req_valid[j] && bus.req_prn[i] == bus.req_prn[j])
                    dup_prn = 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) !dup_prn)
        else $error("prf_wb_arbiter: duplicate req_prn among valid requesters");
endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Directed self-checking bench for prf_wb_arbiter with default parameters (6 req, 4 ports).
module tb_prf_wb_arbiter;
    localparam int unsigned N_REQ    = 6;
    localparam int unsigned W_PORTS  = 4;
    localparam int unsigned PRN_BITS = 6;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    prf_wb_arbiter_if #(.N_REQ(N_REQ), .W_PORTS(W_PORTS), .PRN_BITS(PRN_BITS)) bus ();

    prf_wb_arbiter #(.N_REQ(N_REQ), .W_PORTS(W_PORTS), .PRN_BITS(PRN_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_prn[i]  = PRN_BITS'(10 + i);
            bus.req_data[i] = 64'(100 + i);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.req_valid = '1;
        #1;
        n_checks++;
        if (bus.req_ready !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_ready0: got %b want 000000", bus.req_ready);
        end
        cyc();
        n_checks++;
        if (bus.req_ready !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_ready1: got %b want 000000", bus.req_ready);
        end
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;
        #1;
        n_checks++;
        if (bus.wb_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_wen: got %b want 0000", bus.wb_wen);
        end
        n_checks++;
        if (dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr);
        end
    endtask

    task automatic test_three_way();
        idle_inputs();
        bus.req_valid   = 6'b000111;
        bus.req_prn[0]  = 6'd5;
        bus.req_prn[1]  = 6'd6;
        bus.req_prn[2]  = 6'd7;
        bus.req_data[0] = 64'hA;
        bus.req_data[1] = 64'hB;
        bus.req_data[2] = 64'hC;
        #1;
        n_checks++;
        if (bus.req_ready !== 6'b000111) begin
            n_fail++;
            $display("FAIL three_ready: got %b want 000111", bus.req_ready);
        end
        cyc();
        bus.req_valid = '0;
        n_checks++;
        if (bus.wb_wen !== 4'b0111) begin
            n_fail++;
            $display("FAIL three_wen: got %b want 0111", bus.wb_wen);
        end
        n_checks++;
        if ({bus.wb_wprn[2], bus.wb_wprn[1], bus.wb_wprn[0]} !== {6'd7, 6'd6, 6'd5}) begin
            n_fail++;
            $display("FAIL three_prn: got %0d,%0d,%0d want 5,6,7",
                     bus.wb_wprn[0], bus.wb_wprn[1], bus.wb_wprn[2]);
        end
        n_checks++;
        if ({bus.wb_wdata[2], bus.wb_wdata[1], bus.wb_wdata[0]} !== {64'hC, 64'hB, 64'hA}) begin
            n_fail++;
            $display("FAIL three_data: got %h,%h,%h want a,b,c",
                     bus.wb_wdata[0], bus.wb_wdata[1], bus.wb_wdata[2]);
        end
        n_checks++;
        if (dut.rr_ptr !== 3'd3) begin
            n_fail++;
            $display("FAIL three_ptr: got %0d want 3", dut.rr_ptr);
        end
        cyc();
        n_checks++;
        if (bus.wb_wen !== 4'b0000 || dut.rr_ptr !== 3'd3) begin
            n_fail++;
            $display("FAIL idle_hold: got wen %b ptr %0d want 0000 ptr 3", bus.wb_wen, dut.rr_ptr);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_all_valid();
        logic [5:0]                       exp_ready [3];
        logic [3:0][2:0]                  exp_src   [3];
        logic [2:0]                       exp_ptr   [3];
        logic [W_PORTS-1:0][PRN_BITS-1:0] exp_prn;
        exp_ready[0] = 6'b001111; exp_src[0] = {3'd3, 3'd2, 3'd1, 3'd0}; exp_ptr[0] = 3'd4;
        exp_ready[1] = 6'b110011; exp_src[1] = {3'd1, 3'd0, 3'd5, 3'd4}; exp_ptr[1] = 3'd2;
        exp_ready[2] = 6'b111100; exp_src[2] = {3'd5, 3'd4, 3'd3, 3'd2}; exp_ptr[2] = 3'd0;
        idle_inputs();
        bus.req_valid = '1;
        for (int r = 0; r < 3; r++) begin
            #1;
            n_checks++;
            if (bus.req_ready !== exp_ready[r]) begin
                n_fail++;
                $display("FAIL rr_ready%0d: got %b want %b", r, bus.req_ready, exp_ready[r]);
            end
            cyc();
            for (int k = 0; k < 4; k++) exp_prn[k] = PRN_BITS'(10 + exp_src[r][k]);
            n_checks++;
            if (bus.wb_wen !== 4'b1111 || bus.wb_wprn !== exp_prn) begin
                n_fail++;
                $display("FAIL rr_ports%0d: got wen %b prn %h want 1111 prn %h",
                         r, bus.wb_wen, bus.wb_wprn, exp_prn);
            end
            n_checks++;
            if (dut.rr_ptr !== exp_ptr[r]) begin
                n_fail++;
                $display("FAIL rr_ptr%0d: got %0d want %0d", r, dut.rr_ptr, exp_ptr[r]);
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_wrap();
        idle_inputs();
        // Requesters 0,1 move rr_ptr from 0 to 2.
        bus.req_valid = 6'b000011;
        cyc();
        n_checks++;
        if (dut.rr_ptr !== 3'd2) begin
            n_fail++;
            $display("FAIL wrap_setup_ptr: got %0d want 2", dut.rr_ptr);
        end
        bus.req_valid   = 6'b100000;
        bus.req_prn[5]  = 6'd63;
        bus.req_data[5] = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        n_checks++;
        if (bus.req_ready !== 6'b100000) begin
            n_fail++;
            $display("FAIL wrap_ready: got %b want 100000", bus.req_ready);
        end
        cyc();
        bus.req_valid = '0;
        n_checks++;
        if (bus.wb_wen !== 4'b0001 || bus.wb_wprn[0] !== 6'd63
            || bus.wb_wdata[0] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL wrap_port0: got wen %b prn %0d data %h want 0001 63 ffffffffffffffff",
                     bus.wb_wen, bus.wb_wprn[0], bus.wb_wdata[0]);
        end
        n_checks++;
        if (dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL wrap_ptr: got %0d want 0", dut.rr_ptr);
        end
    endtask

    task automatic test_back_to_back();
        idle_inputs();
        bus.req_valid  = 6'b000010;
        bus.req_prn[1] = 6'd20;
        for (int c = 0; c < 10; c++) begin
            bus.req_data[1] = 64'(c);
            #1;
            n_checks++;
            if (bus.req_ready !== 6'b000010) begin
                n_fail++;
                $display("FAIL b2b_ready%0d: got %b want 000010", c, bus.req_ready);
            end
            cyc();
            n_checks++;
            if (bus.wb_wen !== 4'b0001 || bus.wb_wdata[0] !== 64'(c)) begin
                n_fail++;
                $display("FAIL b2b_out%0d: got wen %b data %0d want 0001 %0d",
                         c, bus.wb_wen, bus.wb_wdata[0], c);
            end
        end
        bus.req_valid = '0;
        cyc();
        n_checks++;
        if (bus.wb_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL b2b_drain: got %b want 0000", bus.wb_wen);
        end
    endtask

    task automatic test_reset_drop();
        // rr_ptr is 2 here; valid {0,1,2} grants 2,0,1.
        idle_inputs();
        bus.req_valid = 6'b000111;
        cyc();
        n_checks++;
        if (bus.wb_wen !== 4'b0111 || bus.wb_wprn[0] !== 6'd12 || bus.wb_wprn[1] !== 6'd10) begin
            n_fail++;
            $display("FAIL drop_grant: got wen %b prn0 %0d prn1 %0d want 0111 12 10",
                     bus.wb_wen, bus.wb_wprn[0], bus.wb_wprn[1]);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.req_ready !== 6'b000000) begin
            n_fail++;
            $display("FAIL drop_ready: got %b want 000000", bus.req_ready);
        end
        cyc();
        rst = 1'b0;
        bus.req_valid = '0;
        n_checks++;
        if (bus.wb_wen !== 4'b0000 || dut.rr_ptr !== 3'd0) begin
            n_fail++;
            $display("FAIL drop_after: got wen %b ptr %0d want 0000 ptr 0", bus.wb_wen, dut.rr_ptr);
        end
        cyc();
        n_checks++;
        if (bus.wb_wen !== 4'b0000) begin
            n_fail++;
            $display("FAIL drop_nowrite: got %b want 0000", bus.wb_wen);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        cyc();
        test_reset();
        test_three_way();
        pulse_reset();
        test_all_valid();
        test_wrap();
        test_back_to_back();
        test_reset_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
